rob_reorder_queue: RTL and testbench
====================================

# rob_reorder_queue

Parametrised reorder queue: entries are allocated in program order at the tail, completed out of order through `p_nwb` independent writeback ports, and retired strictly in order from the head. It supersedes the flat occupancy-register collection in the `rob` directory. It adds the following, which the flat collection lacks:
- head/tail pointer management;
- per-entry three-state tracking;
- multi-port writeback;
- a val/rdy commit interface;
- a global flush.

## Interface
- `p_depth`, 16: number of entries. Must be a power of two, ≥ 2; checked by elaboration assertion.
- `p_ptrwidth`, `$clog2(p_depth)`: index width.
- `p_bitwidth`, 32: payload width.
- `p_nwb`, 2: number of writeback ports, ≥ 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `alloc_val`  in  1  allocation request.
- `alloc_rdy`  out  1  entry available.
- `alloc_idx`  out  p_ptrwidth  index granted on an alloc fire; equals the tail pointer.
- `wb_val`  in  [p_nwb] x 1  writeback valid, one per port.
- `wb_idx`  in  [p_nwb] x p_ptrwidth  target entry.
- `wb_data`  in  [p_nwb] x p_bitwidth  result payload.
- `wb_err`  out  1  registered pulse: some valid writeback targeted a non-PENDING entry last cycle.
- `deq_val`  out  1  head entry is DONE.
- `deq_rdy`  in  1  consumer accepts the head.
- `deq_idx`  out  p_ptrwidth  head pointer.
- `deq_data`  out  p_bitwidth  head payload.
- `flush`  in  1  discard all entries.
- `occ`  out  p_depth  bit i set when entry i is not FREE.
- `count`  out  p_ptrwidth+1  number of non-FREE entries.

## Operation
- **Entry states:** FREE, PENDING, DONE.
- **Pointers:** `head` and `tail`, each p_ptrwidth bits, wrapping mod p_depth. `count` is kept separately, so full and empty are unambiguous.
- **Alloc fire:** `alloc_val && alloc_rdy`.
  - The entry at `tail` goes FREE→PENDING and `tail` increments.
  - `alloc_rdy = (count != p_depth)`. There is no same-cycle bypass: when full, a simultaneous dequeue does not enable the allocation.
- **Writeback:** a port i with `wb_val[i]` and the target entry PENDING writes `wb_data[i]` into that entry, and the entry goes to DONE.
  - If several ports hit the same index in one cycle, the lowest port number wins; the others are dropped silently (no error).
  - A writeback to a FREE or DONE entry is ignored, and `wb_err` is set for the next cycle.
- **Dequeue:**
  - `deq_val = (state[head] == DONE)`, decoded from registered state only.
  - `deq_data` is the head payload, `deq_idx = head`.
  - Fire = `deq_val && deq_rdy`: the head entry goes to FREE and `head` increments.
- **Simultaneous alloc and deq:** both take effect; `count` is unchanged.
- **Single-entry case:** alloc and deq in the same cycle on the same index is impossible. The tail equals the head only when the queue is empty or full, and the rules above exclude both.
- **Flush:**
  - All entries go to FREE; `head`, `tail` and `count` go to 0; `wb_err` goes to 0 next cycle.
  - Flush overrides any alloc, writeback or deq in the same cycle.
  - `alloc_rdy` and `deq_val` still reflect pre-flush state during the flush cycle. Fires in that cycle are lost and are not retired.
- **Reset:** all entries FREE, `head` = `tail` = 0, `count` = 0, `wb_err` = 0. Payload registers are not reset.
  - Resulting outputs: `alloc_rdy` = 1, `alloc_idx` = 0, `deq_val` = 0, `deq_idx` = 0, `occ` = 0.
  - Reset asserted mid-operation clears state immediately, independent of the clock.

## Timing
- **Alloc:** the fire at edge N makes the entry PENDING, visible in `occ` after edge N.
- **Writeback to dequeue:** a writeback accepted at edge N gives `deq_val` = 1 in cycle N+1 if the entry is at the head. There is no combinational path from `wb_*` to `deq_*`.
- **Dequeue:** the fire at edge N makes the next head visible in cycle N+1. Back-to-back retirement runs at one entry per cycle when consecutive entries are DONE.
- **Handshake rules:**
  - `alloc_rdy` and `deq_val` never depend combinationally on `alloc_val` or `deq_rdy`.
  - Producers may hold `alloc_val` high; `alloc_idx` is stable until the fire.

## Structure
- **`rob_pkg`:** the `rob_state_e` enum (FREE = 2'd0, PENDING = 2'd1, DONE = 2'd2).
- **Sub-module `rob_entry`:** state register plus payload register. Inputs are alloc, wb_sel, wb_data, free and flush; outputs are state and data. It is instantiated p_depth times in a generate loop.
- **Top level:** holds the pointers, `count`, writeback priority select per entry, and the head mux.

## Test plan
1. Reset, then 3 allocs → `alloc_idx` 0, 1, 2; `occ` = 0x0007; `count` = 3; `deq_val` = 0.
2. With entries 0–2 PENDING, write back idx 2 (0xC), then 0 (0xA), then 1 (0xB). `deq_val` rises only after idx 0 is written, one cycle later. With `deq_rdy` held high, the retire order is 0xA, 0xB, 0xC on consecutive cycles; `count` ends at 0.
3. Fill p_depth = 4:
   - `alloc_rdy` = 0.
   - Alloc together with deq while full → the alloc is refused.
   - Next cycle `alloc_rdy` = 1 and `alloc_idx` = 0 (wrap).
   - After 8 total alloc/retire pairs, `head` = `tail` = 0.
4. Ports 0 and 1 write idx 3 in the same cycle with 0x11 and 0x22 → stored value 0x11, `wb_err` = 0. A repeat write to idx 3 (now DONE) → `wb_err` = 1 for one cycle, data unchanged.
5. With 3 entries live, assert flush together with `alloc_val` and `wb_val` → next cycle `count` = 0, `occ` = 0, `alloc_idx` = 0, `deq_val` = 0.
6. Assert `rst` asynchronously between edges while 2 entries are DONE → outputs clear immediately to the reset values above.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types for the reorder queue.
//   rob_state_e : per-entry lifecycle (FREE -> PENDING -> DONE -> FREE)
package rob_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    PENDING = 2'd1,
    DONE    = 2'd2
  } rob_state_e;

endpackage

// File: rtl/rob_reorder_queue_if.sv
// Handshake bundle for the reorder queue.
//   master : producer/consumer side (alloc_val, wb_*, deq_rdy, flush out)
//   slave  : queue side (alloc_rdy/idx, wb_err, deq_*, occ, count out)
interface rob_reorder_queue_if #(
  parameter int p_depth    = 16,
  parameter int p_bitwidth = 32,
  parameter int p_nwb      = 2
);
  localparam int p_ptrwidth = $clog2(p_depth);

  logic                                  alloc_val;
  logic                                  alloc_rdy;
  logic [p_ptrwidth-1:0]                 alloc_idx;
  logic [p_nwb-1:0]                      wb_val;
  logic [p_nwb-1:0][p_ptrwidth-1:0]      wb_idx;
  logic [p_nwb-1:0][p_bitwidth-1:0]      wb_data;
  logic                                  wb_err;
  logic                                  deq_val;
  logic                                  deq_rdy;
  logic [p_ptrwidth-1:0]                 deq_idx;
  logic [p_bitwidth-1:0]                 deq_data;
  logic                                  flush;
  logic [p_depth-1:0]                    occ;
  logic [p_ptrwidth:0]                   count;

  modport master (
    output alloc_val, wb_val, wb_idx, wb_data, deq_rdy, flush,
    input  alloc_rdy, alloc_idx, wb_err, deq_val, deq_idx, deq_data, occ, count
  );

  modport slave (
    input  alloc_val, wb_val, wb_idx, wb_data, deq_rdy, flush,
    output alloc_rdy, alloc_idx, wb_err, deq_val, deq_idx, deq_data, occ, count
  );
endinterface

// File: rtl/rob_entry.sv
// One reorder-queue slot: lifecycle state plus result payload.
//   alloc   : claim the slot (FREE -> PENDING)
//   wb_sel  : accepted writeback, only asserted while PENDING (-> DONE)
//   free    : retired from the head (DONE -> FREE)
//   flush   : discard, wins over everything else
//   state/data : registered slot contents
//
// state   | meaning
// FREE    | unallocated
// PENDING | allocated, waiting for its writeback
// DONE    | result held, eligible to retire when at the head
module rob_entry
  import rob_pkg::*;
#(
  parameter int p_bitwidth = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc,
  input  logic                  wb_sel,
  input  logic [p_bitwidth-1:0] wb_data,
  input  logic                  free,
  input  logic                  flush,
  output rob_state_e            state,
  output logic [p_bitwidth-1:0] data
);

  rob_state_e            state_q, state_d;
  logic [p_bitwidth-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (flush) begin
      state_d = FREE;
    end else if (alloc) begin
      state_d = PENDING;
    end else if (wb_sel) begin
      state_d = DONE;
      data_d  = wb_data;
    end else if (free) begin
      state_d = FREE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FREE;
    else     state_q <= state_d;
  end

  // Payload is meaningless until written back, so it carries no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign state = state_q;
  assign data  = data_q;

endmodule

// File: rtl/rob_reorder_queue.sv
// Reorder queue: in-order allocation at the tail, out-of-order completion
// through p_nwb writeback ports, in-order retirement from the head.
//   clk, rst : clock and async active-high reset
//   rq       : rob_reorder_queue_if.slave (alloc, writeback, dequeue, flush,
//              occupancy/count status)
module rob_reorder_queue
  import rob_pkg::*;
#(
  parameter int p_depth    = 16,
  parameter int p_ptrwidth = $clog2(p_depth),
  parameter int p_bitwidth = 32,
  parameter int p_nwb      = 2
) (
  input  logic               clk,
  input  logic               rst,
  rob_reorder_queue_if.slave rq
);

  if (p_depth < 2 || (p_depth & (p_depth - 1)) != 0) begin : g_bad_depth
    $error("rob_reorder_queue: p_depth must be a power of two >= 2");
  end
  if (p_nwb < 1) begin : g_bad_nwb
    $error("rob_reorder_queue: p_nwb must be >= 1");
  end

  localparam logic [p_ptrwidth-1:0] ptr_one    = p_ptrwidth'(1);
  localparam logic [p_ptrwidth:0]   cnt_one    = (p_ptrwidth + 1)'(1);
  localparam logic [p_ptrwidth:0]   full_count = (p_ptrwidth + 1)'(p_depth);

  logic [p_ptrwidth-1:0] head_q, head_d, tail_q, tail_d;
  logic [p_ptrwidth:0]   count_q, count_d;
  logic                  wb_err_q, wb_err_d;

  rob_state_e            ent_state   [p_depth];
  logic [p_bitwidth-1:0] ent_data    [p_depth];
  logic [p_bitwidth-1:0] ent_wb_data [p_depth];
  logic [p_depth-1:0]    ent_alloc, ent_wb_sel, ent_free;

  logic alloc_fire, deq_fire;

  // Both handshakes decode from registered state only.
  assign rq.alloc_rdy = (count_q != full_count);
  assign rq.deq_val   = (ent_state[head_q] == DONE);
  assign alloc_fire   = rq.alloc_val && rq.alloc_rdy;
  assign deq_fire     = rq.deq_val && rq.deq_rdy;

  // Per-entry writeback select: scanning ports from high to low lets the
  // lowest-numbered hitting port win.
  always_comb begin
    for (int e = 0; e < p_depth; e++) begin
      ent_wb_sel[e]  = 1'b0;
      ent_wb_data[e] = '0;
      for (int i = p_nwb - 1; i >= 0; i--) begin
        if (rq.wb_val[i] && (int'(rq.wb_idx[i]) == e)) begin
          ent_wb_sel[e]  = (ent_state[e] == PENDING);
          ent_wb_data[e] = rq.wb_data[i];
        end
      end
      ent_alloc[e] = alloc_fire && (int'(tail_q) == e);
      ent_free[e]  = deq_fire && (int'(head_q) == e);
    end
  end

  // Losing ports on a PENDING target are not errors; only FREE/DONE targets are.
  always_comb begin
    wb_err_d = 1'b0;
    for (int i = 0; i < p_nwb; i++) begin
      if (rq.wb_val[i] && (ent_state[rq.wb_idx[i]] != PENDING)) wb_err_d = 1'b1;
    end
    if (rq.flush) wb_err_d = 1'b0;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (alloc_fire) tail_d = tail_q + ptr_one;
    if (deq_fire)   head_d = head_q + ptr_one;
    case ({alloc_fire, deq_fire})
      2'b10:   count_d = count_q + cnt_one;
      2'b01:   count_d = count_q - cnt_one;
      default: count_d = count_q;
    endcase
    if (rq.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      wb_err_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      wb_err_q <= wb_err_d;
    end
  end

  for (genvar g = 0; g < p_depth; g++) begin : g_entry
    rob_entry #(.p_bitwidth(p_bitwidth)) u_entry (
      .clk     (clk),
      .rst     (rst),
      .alloc   (ent_alloc[g]),
      .wb_sel  (ent_wb_sel[g]),
      .wb_data (ent_wb_data[g]),
      .free    (ent_free[g]),
      .flush   (rq.flush),
      .state   (ent_state[g]),
      .data    (ent_data[g])
    );
  end

  always_comb begin
    for (int e = 0; e < p_depth; e++) rq.occ[e] = (ent_state[e] != FREE);
  end

  assign rq.alloc_idx = tail_q;
  assign rq.deq_idx   = head_q;
  assign rq.deq_data  = ent_data[head_q];
  assign rq.wb_err    = wb_err_q;
  assign rq.count     = count_q;

endmodule

// File: tb/tb_rob_reorder_queue.sv
module tb_rob_reorder_queue;

  localparam int DEPTH = 4;
  localparam int PW    = 2;
  localparam int BW    = 32;
  localparam int NWB   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rob_reorder_queue_if #(.p_depth(DEPTH), .p_bitwidth(BW), .p_nwb(NWB)) bus ();

  rob_reorder_queue #(.p_depth(DEPTH), .p_ptrwidth(PW), .p_bitwidth(BW), .p_nwb(NWB)) dut (
    .clk (clk),
    .rst (rst),
    .rq  (bus)
  );

  typedef struct packed {
    logic [PW-1:0] idx;
    logic [BW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [PW-1:0] idx, input logic [BW-1:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic clr_wb();
    bus.wb_val  = '0;
    bus.wb_idx  = '0;
    bus.wb_data = '0;
  endtask

  task automatic wb(input int port, input logic [PW-1:0] idx, input logic [BW-1:0] data);
    bus.wb_val[port]  = 1'b1;
    bus.wb_idx[port]  = idx;
    bus.wb_data[port] = data;
  endtask

  // Retirement monitor: every dequeue fire is compared against the next
  // expected (index, payload) pair.
  always @(negedge clk) begin
    if (!rst && !bus.flush && bus.deq_val && bus.deq_rdy) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL retire_unexpected: got idx %0d data 0x%0h, expected none",
                 bus.deq_idx, bus.deq_data);
      end else begin
        e = sb_q.pop_front();
        chk("retire_idx", 64'(bus.deq_idx), 64'(e.idx));
        chk("retire_data", 64'(bus.deq_data), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.alloc_val = 1'b0;
    bus.deq_rdy   = 1'b0;
    bus.flush     = 1'b0;
    clr_wb();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_alloc_rdy", 64'(bus.alloc_rdy), 64'd1);
    chk("reset_alloc_idx", 64'(bus.alloc_idx), 64'd0);
    chk("reset_deq_val", 64'(bus.deq_val), 64'd0);
    chk("reset_occ", 64'(bus.occ), 64'd0);
    chk("reset_count", 64'(bus.count), 64'd0);
    rst = 1'b0;
    step();

    // 1: three allocations
    bus.alloc_val = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t1_alloc_idx", 64'(bus.alloc_idx), 64'(k));
      step();
    end
    bus.alloc_val = 1'b0;
    chk("t1_occ", 64'(bus.occ), 64'h7);
    chk("t1_count", 64'(bus.count), 64'd3);
    chk("t1_deq_val", 64'(bus.deq_val), 64'd0);

    // 2: out-of-order completion, in-order retirement
    push_exp(2'd0, 32'hA);
    push_exp(2'd1, 32'hB);
    push_exp(2'd2, 32'hC);
    wb(0, 2'd2, 32'hC);
    step();
    clr_wb();
    chk("t2_deq_val_after_c", 64'(bus.deq_val), 64'd0);
    wb(0, 2'd0, 32'hA);
    chk("t2_deq_val_same_cycle", 64'(bus.deq_val), 64'd0);
    step();
    clr_wb();
    chk("t2_deq_val_after_a", 64'(bus.deq_val), 64'd1);
    chk("t2_wb_err", 64'(bus.wb_err), 64'd0);
    bus.deq_rdy = 1'b1;
    wb(0, 2'd1, 32'hB);
    step();
    clr_wb();
    step();
    step();
    bus.deq_rdy = 1'b0;
    chk("t2_count", 64'(bus.count), 64'd0);
    chk("t2_deq_val_empty", 64'(bus.deq_val), 64'd0);

    // 3: fill, refused alloc while full, wraparound
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.alloc_val = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      chk("t3_fill_idx", 64'(bus.alloc_idx), 64'(k));
      step();
    end
    bus.alloc_val = 1'b0;
    chk("t3_full_rdy", 64'(bus.alloc_rdy), 64'd0);
    chk("t3_full_count", 64'(bus.count), 64'd4);
    push_exp(2'd0, 32'h200);
    wb(0, 2'd0, 32'h200);
    step();
    clr_wb();
    bus.alloc_val = 1'b1;
    bus.deq_rdy   = 1'b1;
    chk("t3_full_rdy_with_deq", 64'(bus.alloc_rdy), 64'd0);
    step();
    bus.alloc_val = 1'b0;
    bus.deq_rdy   = 1'b0;
    chk("t3_rdy_after_deq", 64'(bus.alloc_rdy), 64'd1);
    chk("t3_wrap_idx", 64'(bus.alloc_idx), 64'd0);
    chk("t3_count_after_refuse", 64'(bus.count), 64'd3);
    for (int k = 4; k < 8; k++) begin
      logic [PW-1:0] h;
      h = PW'(k - 3);
      bus.alloc_val = 1'b1;
      chk("t3_loop_alloc_idx", 64'(bus.alloc_idx), 64'(k % DEPTH));
      push_exp(h, 32'h300 + 32'(k));
      wb(0, h, 32'h300 + 32'(k));
      step();
      bus.alloc_val = 1'b0;
      clr_wb();
      bus.deq_rdy = 1'b1;
      step();
      bus.deq_rdy = 1'b0;
    end
    push_exp(2'd1, 32'h401);
    push_exp(2'd2, 32'h402);
    wb(0, 2'd1, 32'h401);
    wb(1, 2'd2, 32'h402);
    step();
    clr_wb();
    push_exp(2'd3, 32'h403);
    wb(0, 2'd3, 32'h403);
    bus.deq_rdy = 1'b1;
    step();
    clr_wb();
    step();
    step();
    bus.deq_rdy = 1'b0;
    chk("t3_end_count", 64'(bus.count), 64'd0);
    chk("t3_end_head", 64'(bus.deq_idx), 64'd0);
    chk("t3_end_tail", 64'(bus.alloc_idx), 64'd0);

    // 4: same-index port collision, writeback to DONE and FREE entries
    bus.alloc_val = 1'b1;
    repeat (DEPTH) step();
    bus.alloc_val = 1'b0;
    wb(0, 2'd3, 32'h11);
    wb(1, 2'd3, 32'h22);
    step();
    clr_wb();
    chk("t4_collide_wb_err", 64'(bus.wb_err), 64'd0);
    wb(1, 2'd3, 32'h33);
    step();
    clr_wb();
    chk("t4_done_wb_err", 64'(bus.wb_err), 64'd1);
    step();
    chk("t4_wb_err_pulse", 64'(bus.wb_err), 64'd0);
    push_exp(2'd0, 32'h500);
    push_exp(2'd1, 32'h501);
    wb(0, 2'd0, 32'h500);
    wb(1, 2'd1, 32'h501);
    step();
    clr_wb();
    push_exp(2'd2, 32'h502);
    push_exp(2'd3, 32'h11);
    wb(0, 2'd2, 32'h502);
    step();
    clr_wb();
    bus.deq_rdy = 1'b1;
    repeat (4) step();
    bus.deq_rdy = 1'b0;
    chk("t4_count", 64'(bus.count), 64'd0);
    wb(0, 2'd1, 32'h99);
    step();
    clr_wb();
    chk("t4_free_wb_err", 64'(bus.wb_err), 64'd1);

    // 5: flush overrides alloc and writeback
    bus.alloc_val = 1'b1;
    repeat (3) step();
    chk("t5_count_before", 64'(bus.count), 64'd3);
    bus.flush = 1'b1;
    wb(0, 2'd0, 32'h600);
    wb(1, 2'd3, 32'h601);
    chk("t5_rdy_during_flush", 64'(bus.alloc_rdy), 64'd1);
    step();
    bus.flush     = 1'b0;
    bus.alloc_val = 1'b0;
    clr_wb();
    chk("t5_count", 64'(bus.count), 64'd0);
    chk("t5_occ", 64'(bus.occ), 64'd0);
    chk("t5_alloc_idx", 64'(bus.alloc_idx), 64'd0);
    chk("t5_deq_val", 64'(bus.deq_val), 64'd0);
    chk("t5_wb_err", 64'(bus.wb_err), 64'd0);

    // 6: asynchronous reset between edges
    bus.alloc_val = 1'b1;
    repeat (2) step();
    bus.alloc_val = 1'b0;
    wb(0, 2'd0, 32'h700);
    wb(1, 2'd1, 32'h701);
    step();
    clr_wb();
    wb(0, 2'd3, 32'h702);
    step();
    clr_wb();
    chk("t6_pre_deq_val", 64'(bus.deq_val), 64'd1);
    chk("t6_pre_wb_err", 64'(bus.wb_err), 64'd1);
    chk("t6_pre_occ", 64'(bus.occ), 64'h3);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_alloc_rdy", 64'(bus.alloc_rdy), 64'd1);
    chk("t6_alloc_idx", 64'(bus.alloc_idx), 64'd2 - 64'd2);
    chk("t6_deq_val", 64'(bus.deq_val), 64'd0);
    chk("t6_deq_idx", 64'(bus.deq_idx), 64'd0);
    chk("t6_occ", 64'(bus.occ), 64'd0);
    chk("t6_count", 64'(bus.count), 64'd0);
    chk("t6_wb_err", 64'(bus.wb_err), 64'd0);
    step();
    rst = 1'b0;
    step();

    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
